// File: rtl/jedro_1_pkg.sv
// Shared types for the jedro_1 write-back stage: result entry and arbitration source.
package jedro_1_pkg;

  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_ADDR_WIDTH = 5;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/jedro_1_wb_fifo.sv
// Synchronous FIFO of write-back entries; exposes per-slot valid bits and storage
// so the owner can match pending destinations against everything still queued.
module jedro_1_wb_fifo
  import jedro_1_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = wb_entry_t
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_push,
  input  entry_t                  i_data,
  input  logic                    i_pop,
  output entry_t                  o_head,
  output logic                    o_full,
  output logic                    o_empty,
  output logic   [DEPTH-1:0]      o_vld,
  output entry_t [DEPTH-1:0]      o_entries
);

  localparam int PW = $clog2(DEPTH);

  logic   [PW-1:0]    r_wptr;
  logic   [PW-1:0]    r_rptr;
  logic   [PW:0]      r_cnt;
  entry_t [DEPTH-1:0] r_mem;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head    = r_mem[r_rptr];
  assign o_entries = r_mem;

  for (genvar g = 0; g < DEPTH; g++) begin : g_vld
    logic [PW-1:0] w_off;
    assign w_off    = PW'(g) - r_rptr;
    assign o_vld[g] = ({1'b0, w_off} < r_cnt);
  end

endmodule

// File: rtl/jedro_1_writeback.sv
// jedro_1 write-back: round-robin ALU/LSU arbitration onto regfile port C.
// Define JEDRO_1_WB_PENDING_EN to add the qa/qb RAW-hazard query ports.
module jedro_1_writeback
  import jedro_1_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = $clog2(DATA_WIDTH),
  parameter int unsigned LSU_FIFO_DEPTH = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      alu_valid_i,
  output logic                      alu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] alu_addr_i,
  input  logic [DATA_WIDTH-1:0]     alu_data_i,
  input  logic                      lsu_valid_i,
  output logic                      lsu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0]     lsu_data_i,
  output logic                      wpc_we_o,
  output logic [REG_ADDR_WIDTH-1:0] wpc_addr_o,
  output logic [DATA_WIDTH-1:0]     wpc_data_o
`ifdef JEDRO_1_WB_PENDING_EN
  ,
  input  logic [REG_ADDR_WIDTH-1:0] qa_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] qb_addr_i,
  output logic                      qa_pending_o,
  output logic                      qb_pending_o
`endif
);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     data;
  } ent_t;

  ent_t                      w_alu_ent;
  ent_t                      w_lsu_ent;
  ent_t                      w_head;
  ent_t                      w_gnt_ent;
  ent_t [LSU_FIFO_DEPTH-1:0] w_entries;
  logic [LSU_FIFO_DEPTH-1:0] w_vld;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_gnt_alu;
  logic                      w_gnt_lsu;
  logic                      w_tie;
  logic                      w_push;
  logic                      w_pop;

  wb_src_e                   r_rr;
  logic                      r_we;
  logic [REG_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_data;

  assign w_alu_ent = '{addr: alu_addr_i, data: alu_data_i};
  assign w_lsu_ent = '{addr: lsu_addr_i, data: lsu_data_i};

  // No pass-through: a full FIFO refuses even if it pops this cycle.
  assign lsu_ready_o = rstn_i && !w_full;
  assign w_push      = lsu_valid_i && lsu_ready_o;

  always_comb begin
    w_tie     = alu_valid_i && !w_empty;
    w_gnt_alu = alu_valid_i && (w_empty || (r_rr == WB_SRC_LSU));
    w_gnt_lsu = !w_empty && !w_gnt_alu;
    w_gnt_ent = w_gnt_alu ? w_alu_ent : w_head;
  end

  assign alu_ready_o = rstn_i && w_gnt_alu;
  assign w_pop       = rstn_i && w_gnt_lsu;

  jedro_1_wb_fifo #(
    .DEPTH   (LSU_FIFO_DEPTH),
    .entry_t (ent_t)
  ) u_lsu_fifo (
    .i_clk     (clk_i),
    .i_rstn    (rstn_i),
    .i_push    (w_push),
    .i_data    (w_lsu_ent),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_vld     (w_vld),
    .o_entries (w_entries)
  );

  // rr_q only moves on a genuine tie; x0 still consumes its grant but never writes.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_rr   <= WB_SRC_ALU;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      if (w_tie) r_rr <= w_gnt_alu ? WB_SRC_ALU : WB_SRC_LSU;
      r_we <= (w_gnt_alu || w_gnt_lsu) && (w_gnt_ent.addr != '0);
      if (w_gnt_alu || w_gnt_lsu) begin
        r_addr <= w_gnt_ent.addr;
        r_data <= w_gnt_ent.data;
      end
    end
  end

  assign wpc_we_o   = r_we;
  assign wpc_addr_o = r_addr;
  assign wpc_data_o = r_data;

`ifdef JEDRO_1_WB_PENDING_EN
  always_comb begin
    qa_pending_o = r_we && (r_addr == qa_addr_i);
    qb_pending_o = r_we && (r_addr == qb_addr_i);
    for (int i = 0; i < int'(LSU_FIFO_DEPTH); i++) begin
      if (w_vld[i] && (w_entries[i].addr == qa_addr_i)) qa_pending_o = 1'b1;
      if (w_vld[i] && (w_entries[i].addr == qb_addr_i)) qb_pending_o = 1'b1;
    end
    if (qa_addr_i == '0) qa_pending_o = 1'b0;
    if (qb_addr_i == '0) qb_pending_o = 1'b0;
  end
`else
  logic w_unused_pend;
  assign w_unused_pend = ^{w_vld, w_entries};
`endif

endmodule
